// File: rtl/mem_stage_hs.sv
// Handshaked EX->WB load/store stage: IDLE/ACCESS/RESP FSM driving a req/ack bus.
// Latency 1 for non-memory ops, 2+ for bus ops; EX is stalled whenever the stage is not IDLE.
module mem_stage_hs #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [3:0]            op_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     store_data_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic                  wb_valid_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  exc_o,
    output logic [2:0]            exc_code_o,
    output logic                  stall_req_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W/8-1:0]   bus_sel_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic                  bus_ack_i,
    input  logic [DATA_W-1:0]     bus_rdata_i,
    input  logic                  bus_err_i
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // Access attributes captured at accept, needed when the ack arrives.
    logic             r_load;
    logic             r_signed;
    logic [1:0]       r_size;
    logic [OFF_W-1:0] r_off;
    logic             r_wreg;

    logic             dec_load, dec_store, dec_signed, dec_misal;
    logic [1:0]       dec_size;
    logic [NB-1:0]    dec_base, dec_sel;
    logic [DATA_W-1:0] dec_wdata;
    logic [OFF_W-1:0] dec_off;

    logic [DATA_W-1:0] shifted, ld_data;
    logic              ld_msb;
    int                ld_bits;

    assign ex_ready_o  = (state == S_IDLE);
    assign stall_req_o = ~ex_ready_o;
    assign wb_valid_o  = (state == S_RESP);
    assign dec_off     = addr_i[OFF_W-1:0];

    // Size encoding: 0 byte, 1 half, 2 word, 3 doubleword.
    always_comb begin
        dec_load   = 1'b0;
        dec_store  = 1'b0;
        dec_size   = 2'd0;
        dec_signed = 1'b0;
        case (op_i)
            4'd1:  begin dec_load = 1'b1; dec_signed = 1'b1; end
            4'd2:  begin dec_load = 1'b1; dec_signed = 1'b1; dec_size = 2'd1; end
            4'd3:  begin dec_load = 1'b1; dec_signed = 1'b1; dec_size = 2'd2; end
            4'd4:  dec_load = 1'b1;
            4'd5:  begin dec_load = 1'b1; dec_size = 2'd1; end
            4'd6:  dec_store = 1'b1;
            4'd7:  begin dec_store = 1'b1; dec_size = 2'd1; end
            4'd8:  begin dec_store = 1'b1; dec_size = 2'd2; end
            4'd9:  if (DATA_W == 64) begin dec_load = 1'b1; dec_size = 2'd2; end
            4'd10: if (DATA_W == 64) begin dec_load = 1'b1; dec_size = 2'd3; end
            4'd11: if (DATA_W == 64) begin dec_store = 1'b1; dec_size = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        dec_misal = 1'b0;
        dec_base  = '1;
        dec_wdata = store_data_i;
        case (dec_size)
            2'd0: begin
                dec_base  = NB'(1);
                dec_wdata = {NB{store_data_i[7:0]}};
            end
            2'd1: begin
                dec_misal = addr_i[0];
                dec_base  = NB'(3);
                dec_wdata = {(NB/2){store_data_i[15:0]}};
            end
            2'd2: begin
                dec_misal = |addr_i[1:0];
                dec_base  = NB'(15);
                dec_wdata = {(NB/4){store_data_i[31:0]}};
            end
            default: dec_misal = |addr_i[2:0];
        endcase
        dec_sel = dec_base << dec_off;
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted = bus_rdata_i >> {r_off, 3'b000};
        case (r_size)
            2'd0:    begin ld_bits = 8;      ld_msb = shifted[7];        end
            2'd1:    begin ld_bits = 16;     ld_msb = shifted[15];       end
            2'd2:    begin ld_bits = 32;     ld_msb = shifted[31];       end
            default: begin ld_bits = DATA_W; ld_msb = shifted[DATA_W-1]; end
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            ld_data[i] = (i < ld_bits) ? shifted[i] : (r_signed & ld_msb);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            r_load      <= 1'b0;
            r_signed    <= 1'b0;
            r_size      <= 2'd0;
            r_off       <= '0;
            r_wreg      <= 1'b0;
            wd_o        <= '0;
            wreg_o      <= 1'b0;
            wdata_o     <= '0;
            exc_o       <= 1'b0;
            exc_code_o  <= 3'd0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= '0;
            bus_wdata_o <= '0;
        end else begin
            case (state)
                S_IDLE: if (ex_valid_i) begin
                    cnt        <= '0;
                    r_load     <= dec_load;
                    r_signed   <= dec_signed;
                    r_size     <= dec_size;
                    r_off      <= dec_off;
                    r_wreg     <= wreg_i;
                    wd_o       <= wd_i;
                    exc_o      <= 1'b0;
                    exc_code_o <= 3'd0;
                    if (dec_load || dec_store) begin
                        wreg_o  <= 1'b0;
                        wdata_o <= '0;
                        if (dec_misal) begin
                            state      <= S_RESP;
                            exc_o      <= 1'b1;
                            exc_code_o <= dec_load ? 3'd1 : 3'd2;
                        end else begin
                            state       <= S_ACCESS;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= dec_store;
                            bus_addr_o  <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            bus_sel_o   <= dec_sel;
                            bus_wdata_o <= dec_wdata;
                        end
                    end else begin
                        state   <= S_RESP;
                        wreg_o  <= wreg_i;
                        wdata_o <= wdata_i;
                    end
                end
                S_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (bus_err_i || bus_ack_i || cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= S_RESP;
                        bus_req_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                        bus_sel_o <= '0;
                        if (bus_err_i) begin
                            exc_o      <= 1'b1;
                            exc_code_o <= 3'd4;
                        end else if (bus_ack_i) begin
                            wreg_o  <= r_load & r_wreg;
                            wdata_o <= r_load ? ld_data : '0;
                        end else begin
                            exc_o      <= 1'b1;
                            exc_code_o <= 3'd3;
                        end
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Handshaked, parametrised load/store stage between EX and WB of the pipelined CPU. Replaces the single-cycle combinational memory stage with a registered FSM that drives a req/ack data bus and tolerates wait states. Performs byte-lane select, store-data replication and load extraction (sign/zero extension), including doubleword ops when DATA_W=64. Detects misalignment, bus error and bus timeout, and stalls EX while an access is outstanding.

Parameters:
DATA_W, 32, bus/register data width; legal values 32 or 64.
ADDR_W, 32, address width.
REG_ADDR_W, 5, register-file address width.
TIMEOUT, 255, cycles waiting for ack before a timeout exception; must be >= 1.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
ex_valid_i  in  1  EX presents an op this cycle
ex_ready_o  out  1  stage can accept; equals (state==IDLE)
op_i  in  4  0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW, 9 LWU, 10 LD, 11 SD; 9-11 legal only if DATA_W=64, else treated as NOP; 12-15 treated as NOP
addr_i  in  ADDR_W  effective address
store_data_i  in  DATA_W  store source register
wd_i  in  REG_ADDR_W  destination register
wreg_i  in  1  destination write enable
wdata_i  in  DATA_W  ALU result for non-memory ops
wb_valid_o  out  1  one-cycle pulse: result for WB
wd_o  out  REG_ADDR_W  destination register
wreg_o  out  1  write enable to WB
wdata_o  out  DATA_W  write-back data
exc_o  out  1  exception flag, valid with wb_valid_o
exc_code_o  out  3  0 none, 1 load misaligned, 2 store misaligned, 3 bus timeout, 4 bus error
stall_req_o  out  1  equals !ex_ready_o
bus_req_o  out  1  access request, held until ack/err/timeout
bus_we_o  out  1  1 = write
bus_addr_o  out  ADDR_W  access address, low log2(DATA_W/8) bits forced to 0
bus_sel_o  out  DATA_W/8  byte-lane enables, lane k = byte at address offset k (little-endian)
bus_wdata_o  out  DATA_W  store data
bus_ack_i  in  1  access complete; bus_rdata_i valid same cycle
bus_rdata_i  in  DATA_W  read data
bus_err_i  in  1  access failed

Behaviour:
- Reset: all outputs 0 except ex_ready_o=1; state IDLE; timeout counter 0. Reset mid-access drops bus_req_o on the following cycle, discards the access and produces no wb_valid_o.
- States: IDLE, ACCESS, RESP.
- Accept: edge where ex_valid_i & ex_ready_o. All inputs are registered at the accept edge.
- NOP or other non-memory op: IDLE->RESP. wb_valid_o=1 in the next cycle with wd/wreg/wdata passed through. Latency 1.
- Memory op, aligned: IDLE->ACCESS. bus_req_o, bus_we_o, bus_addr_o, bus_sel_o and bus_wdata_o are registered and stable for the whole ACCESS period.
- Misaligned memory op: IDLE->RESP; no bus_req_o issued. exc_o=1, exc_code_o=1 (load) or 2 (store), wreg_o=0.
- Alignment rules: halfword requires addr[0]=0; word requires addr[1:0]=0; doubleword requires addr[2:0]=0.
- Lane and offset: offset = addr[log2(DATA_W/8)-1:0].
  - SB: sel one-hot at offset; wdata = byte replicated.
  - SH: 2 lanes at offset; wdata = halfword replicated.
  - SW: 4 lanes at offset; wdata = word replicated.
  - SD: all lanes.
  - Loads use the same sel pattern.
- ACCESS: counter increments each cycle. The first of the following to occur ends the access; on all three, bus_req_o drops and the state moves to RESP:
  - bus_err_i: code 4. Has priority over a same-cycle bus_ack_i.
  - bus_ack_i: capture and extract data. Loads sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to DATA_W; stores give wreg_o=0.
  - counter==TIMEOUT without ack/err: code 3.
- Exceptions always force wreg_o=0.
- Ack on the first ACCESS cycle gives minimum load latency of 2 cycles from accept to wb_valid_o.
- RESP: wb_valid_o=1 for exactly one cycle, then IDLE. ex_ready_o=1 again in the cycle after RESP. No back-to-back accept while RESP is active.
- bus_ack_i/bus_err_i are ignored outside ACCESS.

Test Plan:
- ALU pass-through: op=0, wd=7, wreg=1, wdata=0x1234 -> one cycle later wb_valid_o=1, wd_o=7, wdata_o=0x1234, no bus_req_o.
- LB at 0x1003, 2 wait states, rdata=0x80FF_0000 -> bus_sel_o=4'b1000, bus_addr_o=0x1000; wdata_o=0xFFFF_FF80, 4 cycles after accept.
- SH at 0x2002, store_data=0xABCD -> bus_we_o=1, bus_sel_o=4'b1100, bus_wdata_o=0xABCD_ABCD, wreg_o=0.
- LW at 0x3001 -> no bus_req_o; exc_o=1, exc_code_o=1, wreg_o=0, next cycle.
- Faults:
  - ack never arrives, TIMEOUT=4 -> bus_req_o drops after 4 cycles, exc_code_o=3.
  - ack and err in the same cycle -> exc_code_o=4.
- DATA_W=64, LD at 0x10 with rdata=0x0123_4567_89AB_CDEF -> bus_sel_o=8'hFF, wdata_o equals rdata; rst asserted during ACCESS -> bus_req_o=0 next cycle and no wb_valid_o.
